// File: rtl/uart_resp_tx.sv
// rtl/uart_resp_tx.sv - serialises a latched 24-bit response as back-to-back 8N1 UART frames
// MSB byte first, LSB bit first; define RESP_CHKSUM_EN to append an inverted-sum checksum byte.
module uart_resp_tx #(
   parameter int BAUD_DIV = 2604,
   parameter int CNT_W    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        send_resp,
   input  logic [23:0] resp,
   output logic        TX,
   output logic        busy,
   output logic        resp_sent,
   input  logic        clr_resp_sent
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XMIT = 2'd1;
   localparam logic [1:0] ST_NEXT = 2'd2;

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [3:0]       BIT_LAST  = 4'd10;

`ifdef RESP_CHKSUM_EN
   localparam int         HOLD_W   = 32;
   localparam logic [1:0] LAST_IDX = 2'd3;
`else
   localparam int         HOLD_W   = 24;
   localparam logic [1:0] LAST_IDX = 2'd2;
`endif

   logic [1:0]        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [9:0]        frame_q, frame_d;
   logic [CNT_W-1:0]  baud_q, baud_d;
   logic [3:0]        bit_q, bit_d;
   logic [1:0]        idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              sent_q, sent_d;
   logic [HOLD_W-1:0] load_word;

`ifdef RESP_CHKSUM_EN
   logic [7:0] chk_sum;
   always_comb begin
      chk_sum   = resp[23:16] + resp[15:8] + resp[7:0];
      load_word = {resp, ~chk_sum};
   end
`else
   always_comb begin
      load_word = resp;
   end
`endif

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      frame_d = frame_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      sent_d  = sent_q;

      if (clr_resp_sent) begin
         sent_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (send_resp) begin
               hold_d  = load_word;
               frame_d = {1'b1, load_word[HOLD_W-1 -: 8], 1'b0};
               baud_d  = '0;
               bit_d   = 4'd0;
               idx_d   = 2'd0;
               busy_d  = 1'b1;
               sent_d  = 1'b0;
               state_d = ST_XMIT;
            end
         end

         ST_XMIT: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               frame_d = {1'b1, frame_q[9:1]};
               bit_d   = bit_q + 4'd1;
               if (bit_d == BIT_LAST) begin
                  state_d = ST_NEXT;
               end
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end

         ST_NEXT: begin
            bit_d = 4'd0;
            // The holding register shifts up so the next byte is always at the top.
            if (idx_q != LAST_IDX) begin
               idx_d   = idx_q + 2'd1;
               hold_d  = {hold_q[HOLD_W-9:0], 8'h00};
               frame_d = {1'b1, hold_d[HOLD_W-1 -: 8], 1'b0};
               state_d = ST_XMIT;
            end else begin
               idx_d   = 2'd0;
               busy_d  = 1'b0;
               sent_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         frame_q <= 10'h3FF;
         baud_q  <= '0;
         bit_q   <= 4'd0;
         idx_q   <= 2'd0;
         busy_q  <= 1'b0;
         sent_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         frame_q <= frame_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         sent_q  <= sent_d;
      end
   end

   assign TX        = frame_q[0];
   assign busy      = busy_q;
   assign resp_sent = sent_q;

endmodule
